matrix_capture: RTL and testbench
=================================

MATRIX_CAPTURE -- requirements
Module: matrix_capture

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 32, Wishbone data width.
REQ-002 SHALL have parameter REG_COUNT, default 16, register count; fixed by the register map.
REQ-003 SHALL have parameter WB_ADDR_WIDTH, default $clog2(REG_COUNT), Wishbone address width.
REQ-004 SHALL have parameter WB_SEL_WIDTH, default WB_DATA_WIDTH/8, byte-select width.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports i_matrix_clk, i_matrix_latch, i_matrix_mosi, input, 1 bit each: 74HC595-chain shift clock, latch (CE) and data, asynchronous to clk.
REQ-008 SHALL have ports i_wb_cyc, i_wb_stb, i_wb_we, input, 1 bit each; i_wb_addr, input, WB_ADDR_WIDTH bits; i_wb_sel, input, WB_SEL_WIDTH bits; i_wb_wdata, input, WB_DATA_WIDTH bits.
REQ-009 SHALL have ports o_wb_ack, output, 1 bit; o_wb_stall, output, 1 bit; o_wb_rdata, output, WB_DATA_WIDTH bits.

Function
REQ-010 SHALL pass each i_matrix_* input through a 2-FF synchronizer plus one history FF, and detect rising edges on sclk and latch.
REQ-011 SHALL shift on each sclk rising edge: sr <= {sr[30:0], mosi}; 32-bit shift register; the shift completes 3 clk after the input edge.
REQ-012 SHALL keep bit_cnt (6 bits) of sclk rising edges since the last latch edge, saturating at 63.
REQ-013 On each latch rising edge, SHALL copy sr to raw_word, increment latch_cnt (8 bits, wraps), and set bit_cnt to 0.
REQ-014 When sclk and latch rise in the same clk, SHALL apply the shift first; the latch then captures the new sr and bit_cnt becomes 0.
REQ-015 SHALL decode the latched word as follows: red = sr[31:24], blue = sr[23:16], green = sr[15:8], each active-low, column c at bit 7-c of its byte; anode = sr[7:0], active-high, row r at bit 7-r.
REQ-016 When the latch occurs with bit_cnt != 32, SHALL skip decode and increment len_err (8 bits, saturating at 255).
REQ-017 When bit_cnt == 32 and the anode is not one-hot and not zero, SHALL skip decode and increment anode_err (8 bits, saturating at 255).
REQ-018 When bit_cnt == 32 and the anode is zero, SHALL perform no memory update and report no error.
REQ-019 When bit_cnt == 32 and the anode is one-hot (row r), SHALL OR into frame[r] for each column c the nibble {0, red_c, green_c, blue_c} at bits [31-4c:28-4c].
REQ-020 SHALL make a decoded update visible on Wishbone reads issued 2 clk after the latch edge is detected.
REQ-021 SHALL implement the register map as:
- addr 0-7: frame[0..7], read-only.
- addr 8: raw_word, read-only.
- addr 9: status = {2'b0, bit_cnt, anode_err, len_err, latch_cnt}.
- addr 10: ctrl, write-only.
- addr 11-15: read 0.
REQ-022 A ctrl write with wdata[0]=1 and sel[0]=1 SHALL clear frame[0..7], raw_word, latch_cnt, len_err and anode_err; sr and bit_cnt SHALL be unaffected.
REQ-023 When a ctrl clear and a decode update occur in the same clk, the clear SHALL win.
REQ-024 SHALL accept a Wishbone request when i_wb_cyc & i_wb_stb & !o_wb_ack; o_wb_ack SHALL be high for exactly 1 clk, the cycle after acceptance.
REQ-025 For an accepted read, o_wb_rdata SHALL be registered with the ack and SHALL hold its value until the next accepted read.
REQ-026 Writes to read-only addresses SHALL be acked and ignored.
REQ-027 o_wb_stall SHALL be constant 0.

Reset
REQ-028 While reset is high at a clk edge, the block SHALL clear the following to 0: sr, bit_cnt, raw_word, latch_cnt, len_err, anode_err, frame[0..7], o_wb_ack, o_wb_rdata.
REQ-029 While reset is high, the synchronizer history SHALL be loaded with the current synchronized levels, so no spurious edge is seen after reset.
REQ-030 A reset asserted mid-word SHALL discard the partial word; the next latch SHALL then see bit_cnt equal to the number of sclk edges seen since reset.

Verification
REQ-031 Bench SHALL cover: shift 32 bits with red=0x7F, blue=0xFF, green=0xFF, anode=0x80, then latch -> read addr 0 = 0x40000000, addr 8 = 0x7FFFFF80, latch_cnt = 1.
REQ-032 Bench SHALL cover: 256 ones then latch (transmitter reset phase) -> len_err = 1, frame unchanged, raw_word = 0xFFFFFFFF.
REQ-033 Bench SHALL cover: anode=0x81 with 32 bits -> anode_err = 1, no frame update; anode=0x00 -> no error, no update.
REQ-034 Bench SHALL cover: row 3 latched three times with red col0, green col0 and blue col0 active in turn -> frame[3] = 0x70000000.
REQ-035 Bench SHALL cover: ctrl write 0x1 in the same clk as a decode update -> all frame rows and counters read 0 afterwards.
REQ-036 Bench SHALL cover: back-to-back cyc/stb held high -> ack every other clk, stall always 0; reset mid-word followed by 32 bits and a latch -> a correct decode.

Source files
------------

// File: rtl/matrix_capture.sv
// Snoops a 74HC595 LED-matrix chain (sclk/latch/mosi) and accumulates decoded pixels
// into an 8-row frame buffer readable over a pipelined Wishbone slave.
module matrix_capture #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int REG_COUNT     = 16,
  parameter int WB_ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_matrix_clk,
  input  logic                     i_matrix_latch,
  input  logic                     i_matrix_mosi,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [WB_SEL_WIDTH-1:0]  i_wb_sel,
  input  logic [WB_DATA_WIDTH-1:0] i_wb_wdata,
  output logic                     o_wb_ack,
  output logic                     o_wb_stall,
  output logic [WB_DATA_WIDTH-1:0] o_wb_rdata
);

  // Index 0 = sclk, 1 = latch, 2 = mosi
  logic [2:0] sync1_q, sync2_q;
  logic [1:0] hist_q;

  logic [31:0] sr_q, sr_d, sr_shift;
  logic [5:0]  bit_cnt_q, bit_cnt_d, cnt_shift;
  logic [31:0] raw_q, raw_d;
  logic [7:0]  latch_cnt_q, latch_cnt_d;
  logic [7:0]  len_err_q, len_err_d;
  logic [7:0]  anode_err_q, anode_err_d;
  logic [31:0] frame_q [8];
  logic [31:0] frame_d [8];
  logic        ack_q, ack_d;
  logic [WB_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic        sclk_rise, latch_rise;
  logic [7:0]  anode;
  logic        anode_one_hot;
  logic [31:0] pix;
  logic        wb_req, clear;
  logic [31:0] addr_ext, rd_word;
  logic        unused_wb;

  assign sclk_rise  = sync2_q[0] & ~hist_q[0];
  assign latch_rise = sync2_q[1] & ~hist_q[1];

  assign sr_shift  = sclk_rise ? {sr_q[30:0], sync2_q[2]} : sr_q;
  assign cnt_shift = (sclk_rise && bit_cnt_q != 6'd63) ? bit_cnt_q + 6'd1 : bit_cnt_q;

  assign anode         = sr_shift[7:0];
  assign anode_one_hot = (anode != 8'd0) && ((anode & (anode - 8'd1)) == 8'd0);

  assign wb_req    = i_wb_cyc & i_wb_stb & ~ack_q;
  assign clear     = wb_req & i_wb_we & i_wb_sel[0] & i_wb_wdata[0] & (addr_ext == 32'd10);
  assign addr_ext  = 32'(i_wb_addr);
  assign unused_wb = ^{i_wb_sel, i_wb_wdata};

  // Active-low colour bytes become one {0,r,g,b} nibble per column, column 0 in the top nibble
  always_comb begin
    pix = '0;
    for (int c = 0; c < 8; c++) begin
      pix[31-4*c -: 4] = {1'b0, ~sr_shift[31-c], ~sr_shift[15-c], ~sr_shift[23-c]};
    end
  end

  always_comb begin
    sr_d        = sr_shift;
    bit_cnt_d   = latch_rise ? 6'd0 : cnt_shift;
    raw_d       = raw_q;
    latch_cnt_d = latch_cnt_q;
    len_err_d   = len_err_q;
    anode_err_d = anode_err_q;
    frame_d     = frame_q;
    if (latch_rise) begin
      raw_d       = sr_shift;
      latch_cnt_d = latch_cnt_q + 8'd1;
      if (cnt_shift != 6'd32) begin
        if (len_err_q != 8'hFF) len_err_d = len_err_q + 8'd1;
      end else if (anode != 8'd0 && !anode_one_hot) begin
        if (anode_err_q != 8'hFF) anode_err_d = anode_err_q + 8'd1;
      end else if (anode_one_hot) begin
        for (int r = 0; r < 8; r++) begin
          if (anode[7-r]) frame_d[r] = frame_q[r] | pix;
        end
      end
    end
    if (clear) begin
      raw_d       = '0;
      latch_cnt_d = '0;
      len_err_d   = '0;
      anode_err_d = '0;
      for (int r = 0; r < 8; r++) frame_d[r] = '0;
    end
  end

  always_comb begin
    rd_word = '0;
    if (addr_ext < 32'd8) begin
      rd_word = frame_q[addr_ext[2:0]];
    end else if (addr_ext == 32'd8) begin
      rd_word = raw_q;
    end else if (addr_ext == 32'd9) begin
      rd_word = {2'b00, bit_cnt_q, anode_err_q, len_err_q, latch_cnt_q};
    end
    ack_d   = wb_req;
    rdata_d = (wb_req && !i_wb_we) ? WB_DATA_WIDTH'(rd_word) : rdata_q;
  end

  // History always tracks the synchronized level, so reset never leaves a stale low behind
  always_ff @(posedge clk) begin
    sync1_q <= {i_matrix_mosi, i_matrix_latch, i_matrix_clk};
    sync2_q <= sync1_q;
    hist_q  <= sync2_q[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      raw_q       <= '0;
      latch_cnt_q <= '0;
      len_err_q   <= '0;
      anode_err_q <= '0;
      for (int r = 0; r < 8; r++) frame_q[r] <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      raw_q       <= raw_d;
      latch_cnt_q <= latch_cnt_d;
      len_err_q   <= len_err_d;
      anode_err_q <= anode_err_d;
      for (int r = 0; r < 8; r++) frame_q[r] <= frame_d[r];
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_stall = 1'b0;
  assign o_wb_rdata = rdata_q;

endmodule

// File: tb/tb_matrix_capture.sv
// Self-checking bench for matrix_capture: directed scenarios plus random words,
// all checked against a bit-queue/arithmetic model of the capture rules.
module tb_matrix_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mclk = 1'b0, mlatch = 1'b0, mosi = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] wdata = '0;
  logic        ack, stall;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_sr;
  int          m_cnt;
  logic [31:0] m_frame [8];
  logic [31:0] m_raw;
  logic [7:0]  m_lcnt, m_len, m_aerr;

  always #5 clk = ~clk;

  matrix_capture dut (
    .clk            (clk),
    .reset          (reset),
    .i_matrix_clk   (mclk),
    .i_matrix_latch (mlatch),
    .i_matrix_mosi  (mosi),
    .i_wb_cyc       (cyc),
    .i_wb_stb       (stb),
    .i_wb_we        (we),
    .i_wb_addr      (addr),
    .i_wb_sel       (sel),
    .i_wb_wdata     (wdata),
    .o_wb_ack       (ack),
    .o_wb_stall     (stall),
    .o_wb_rdata     (rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void m_clear();
    for (int r = 0; r < 8; r++) m_frame[r] = '0;
    m_raw  = '0;
    m_lcnt = '0;
    m_len  = '0;
    m_aerr = '0;
  endfunction

  function automatic void m_reset();
    m_clear();
    m_sr  = '0;
    m_cnt = 0;
  endfunction

  function automatic void m_shift(input logic b);
    m_sr = {m_sr[30:0], b};
    if (m_cnt < 63) m_cnt++;
  endfunction

  function automatic void m_latch();
    logic [7:0] an, red, grn, blu;
    logic [3:0] nib;
    int row;
    an  = m_sr[7:0];
    red = m_sr[31:24];
    blu = m_sr[23:16];
    grn = m_sr[15:8];
    m_raw  = m_sr;
    m_lcnt = m_lcnt + 8'd1;
    if (m_cnt != 32) begin
      if (m_len != 8'd255) m_len++;
    end else if ($countones(an) > 1) begin
      if (m_aerr != 8'd255) m_aerr++;
    end else if ($countones(an) == 1) begin
      row = 0;
      for (int k = 0; k < 8; k++) if (an[k]) row = 7 - k;
      for (int c = 0; c < 8; c++) begin
        nib = {1'b0, ~red[7-c], ~grn[7-c], ~blu[7-c]};
        m_frame[row] = m_frame[row] | (32'(nib) << (28 - 4*c));
      end
    end
    m_cnt = 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) mosi = b;
    @(negedge clk) mclk = 1'b1;
    @(negedge clk);
    @(negedge clk) mclk = 1'b0;
    m_shift(b);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_latch();
    @(negedge clk) mlatch = 1'b1;
    repeat (2) @(negedge clk);
    mlatch = 1'b0;
    repeat (4) @(negedge clk);
    m_latch();
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    check("rd_ack", {31'b0, ack}, 32'd1);
    d = rdata;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("wr_ack", {31'b0, ack}, 32'd1);
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] d;
    for (int a = 0; a < 8; a++) begin
      wb_read(4'(a), d);
      check($sformatf("%s frame[%0d]", tag, a), d, m_frame[a]);
    end
    wb_read(4'd8, d);
    check({tag, " raw"}, d, m_raw);
    wb_read(4'd9, d);
    check({tag, " status"}, d, {2'b00, 6'(m_cnt), m_aerr, m_len, m_lcnt});
    wb_read(4'd11, d);
    check({tag, " addr11"}, d, 32'd0);
    wb_read(4'd15, d);
    check({tag, " addr15"}, d, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [63:0] v;
    logic [7:0]  an;
    int          len, sel_r;

    m_reset();
    do_reset();
    check("reset ack", {31'b0, ack}, 32'd0);
    check("reset stall", {31'b0, stall}, 32'd0);
    check_regs("reset");

    // Red column 0 on row 0
    send_bits(64'h7FFFFF80, 32);
    do_latch();
    wb_read(4'd0, d);
    check("row0 red", d, 32'h40000000);
    wb_read(4'd8, d);
    check("raw 7FFFFF80", d, 32'h7FFFFF80);
    wb_read(4'd9, d);
    check("latch_cnt 1", {24'b0, d[7:0]}, 32'd1);
    check_regs("basic");

    // Transmitter reset phase: long run of ones
    for (int i = 0; i < 256; i++) send_bit(1'b1);
    do_latch();
    wb_read(4'd9, d);
    check("len_err 1", {24'b0, d[15:8]}, 32'd1);
    check_regs("ones");

    send_bits(64'hFFFFFF81, 32);
    do_latch();
    check_regs("anode81");
    send_bits(64'h00000000, 32);
    do_latch();
    check_regs("anode00");

    // Row 3 accumulated from three colours
    wb_write(4'd10, 32'h1, 4'h1);
    m_clear();
    send_bits(64'h7FFFFF10, 32);
    do_latch();
    send_bits(64'hFFFF7F10, 32);
    do_latch();
    send_bits(64'hFF7FFF10, 32);
    do_latch();
    wb_read(4'd3, d);
    check("row3 rgb", d, 32'h70000000);
    check_regs("row3");

    // Shift and latch rising together
    send_bits(64'h3F7FFF02, 31);
    @(negedge clk) mosi = 1'b0;
    @(negedge clk) begin mclk = 1'b1; mlatch = 1'b1; end
    @(negedge clk);
    @(negedge clk) begin mclk = 1'b0; mlatch = 1'b0; end
    repeat (4) @(negedge clk);
    m_shift(1'b0);
    m_latch();
    check_regs("same_edge");

    // Ctrl clear collides with a decode update
    send_bits(64'h00000040, 32);
    @(negedge clk) mlatch = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 4'd10; wdata = 32'h1; sel = 4'hF;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; mlatch = 1'b0;
    check("clr ack", {31'b0, ack}, 32'd1);
    repeat (4) @(negedge clk);
    m_latch();
    m_clear();
    check_regs("clear_collide");

    // Held request: ack every other clock
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 4'd9;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b ack %0d", i), {31'b0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b stall %0d", i), {31'b0, stall}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);

    // Reset mid-word discards partial bits
    send_bits(64'h3FF, 10);
    do_reset();
    send_bits(64'hFFFF7F04, 32);
    do_latch();
    wb_read(4'd5, d);
    check("post-reset row5", d, 32'h20000000);
    check_regs("mid_reset");

    // Random words against the model
    for (int w = 0; w < 40; w++) begin
      sel_r = $urandom_range(0, 9);
      len   = (sel_r == 0) ? 31 : (sel_r == 1) ? 33 : 32;
      sel_r = $urandom_range(0, 7);
      an    = (sel_r == 0) ? 8'h00 : (sel_r == 1) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      v     = {32'($urandom), 24'($urandom), an};
      send_bits(v, len);
      do_latch();
      if (w % 8 == 7) begin
        wb_write(4'd10, 32'h1, 4'h1);
        m_clear();
      end
      check_regs($sformatf("rand%0d", w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
